// File: rtl/riscv_alu_arbiter.sv
// riscv_alu_arbiter
//
// Shares a single riscv_alu between NREQ requesters. Each requester
// presents an operation with a valid/ready handshake. The arbiter grants
// one operation per cycle when the response slot is free. The ALU result
// is captured on the next edge, tagged with the owner's index, and held
// until that owner drains it. Only one operation is outstanding at a time.
//
// Configuration macro: RISCV_ALU_ARB_RR_EN
//   defined   -> round-robin grant; the search starts just after the last winner
//   undefined -> fixed priority; the lowest requester index wins
//
// Ports
//   clk        : clock; all state changes on the rising edge
//   rst        : synchronous active-high reset
//   req_valid  : [NREQ]        requester i has an operation pending
//   req_ready  : [NREQ]        one-hot grant (combinational)
//   req_a      : [NREQ*WIDTH]  operand a, slice i = [i*WIDTH +: WIDTH]
//   req_b      : [NREQ*WIDTH]  operand b, sliced the same way
//   req_ctrl   : [NREQ*4]      ALU control, slice i = [i*4 +: 4]
//   rsp_valid  : [NREQ]        one-hot; a result is held for requester i
//   rsp_ready  : [NREQ]        requester i accepts its result
//   rsp_data   : [WIDTH]       registered ALU result
//   rsp_zero   : 1             registered zero flag
//   rsp_id     : [IDW]         owner of the held result

// riscv_alu: purely combinational ALU.
// Control codes that are not recognised give result 0 and zero=1.
module riscv_alu #(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       i_ctrl,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero
);

  // Decode the control code into one of the supported operations.
  // Set-less-than compares the operands as unsigned values.
  always_comb begin
    o_result = '0;
    case (i_ctrl)
      4'b0000: o_result = i_a & i_b;
      4'b0001: o_result = i_a | i_b;
      4'b0010: o_result = i_a + i_b;
      4'b0110: o_result = i_a - i_b;
      4'b0111: o_result = (i_a < i_b) ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
      4'b1100: o_result = ~(i_a | i_b);
      default: o_result = '0;
    endcase
  end

  assign o_zero = (o_result == '0);

endmodule

module riscv_alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 2,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*4-1:0]     req_ctrl,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  rsp_zero,
  output logic [IDW-1:0]        rsp_id
);

  logic [NREQ-1:0]  r_rspValid;
  logic [WIDTH-1:0] r_rspData;
  logic             r_rspZero;
  logic [IDW-1:0]   r_rspId;

  logic             w_drain;
  logic             w_slotFree;
  logic             w_found;
  logic             w_grant;
  logic [IDW-1:0]   w_grantIdx;
  logic [WIDTH-1:0] w_aluA;
  logic [WIDTH-1:0] w_aluB;
  logic [3:0]       w_aluCtrl;
  logic [WIDTH-1:0] w_aluResult;
  logic             w_aluZero;

  // rsp_valid is one-hot on the owner. AND-ing it with rsp_ready therefore
  // picks out only the owner's ready, so ready bits from other requesters
  // have no effect.
  assign w_drain    = |(r_rspValid & rsp_ready);
  assign w_slotFree = (r_rspValid == '0) || w_drain;

`ifdef RISCV_ALU_ARB_RR_EN
  logic [IDW-1:0] r_last;

  // Round-robin search. Start one past the previous winner and wrap modulo
  // NREQ. The first requester found with valid set wins.
  always_comb begin
    w_found    = 1'b0;
    w_grantIdx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!w_found && req_valid[(int'(r_last) + k) % NREQ]) begin
        w_found    = 1'b1;
        w_grantIdx = IDW'((int'(r_last) + k) % NREQ);
      end
    end
  end

  // The pointer moves only when a grant is actually issued. Its reset value
  // of NREQ-1 makes requester 0 the first winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= IDW'(NREQ - 1);
    end else if (w_grant) begin
      r_last <= w_grantIdx;
    end
  end
`else
  // Fixed priority. The loop scans downward so that the lowest set index
  // is the last write and therefore wins.
  always_comb begin
    w_found    = 1'b0;
    w_grantIdx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        w_found    = 1'b1;
        w_grantIdx = IDW'(i);
      end
    end
  end
`endif

  assign w_grant = w_slotFree && w_found;

  // One-hot grant. It is issued only when the slot can take a new result.
  always_comb begin
    req_ready = '0;
    if (w_grant) begin
      req_ready[w_grantIdx] = 1'b1;
    end
  end

  // Steer the winner's payload into the shared ALU.
  always_comb begin
    w_aluA    = '0;
    w_aluB    = '0;
    w_aluCtrl = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grantIdx == IDW'(i)) begin
        w_aluA    = req_a[i*WIDTH +: WIDTH];
        w_aluB    = req_b[i*WIDTH +: WIDTH];
        w_aluCtrl = req_ctrl[i*4 +: 4];
      end
    end
  end

  riscv_alu #(.WIDTH(WIDTH)) u_alu (
    .i_ctrl   (w_aluCtrl),
    .i_a      (w_aluA),
    .i_b      (w_aluB),
    .o_result (w_aluResult),
    .o_zero   (w_aluZero)
  );

  // Response slot. A grant takes priority over a drain because draining and
  // refilling on the same edge must load the new result. A drain with no
  // new grant clears only the valid bits; data, zero and id keep their
  // last values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rspValid <= '0;
      r_rspData  <= '0;
      r_rspZero  <= 1'b1;
      r_rspId    <= '0;
    end else if (w_grant) begin
      r_rspValid <= req_ready;
      r_rspData  <= w_aluResult;
      r_rspZero  <= w_aluZero;
      r_rspId    <= w_grantIdx;
    end else if (w_drain) begin
      r_rspValid <= '0;
    end
  end

  assign rsp_valid = r_rspValid;
  assign rsp_data  = r_rspData;
  assign rsp_zero  = r_rspZero;
  assign rsp_id    = r_rspId;

endmodule

// File: tb/tb_riscv_alu_arbiter.sv
// Self-checking bench for riscv_alu_arbiter (WIDTH=32, NREQ=2).
// The reference model holds the response slot as plain variables. It
// selects the winner by the arbitration rules and computes results with
// ordinary arithmetic.
module tb_riscv_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [7:0]  req_ctrl;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_zero;
  logic [0:0]  rsp_id;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit          mFull;
  int          mId;
  logic [31:0] mData;
  bit          mZero;
  int          mLast;

  always #5 clk = ~clk;

  riscv_alu_arbiter #(.WIDTH(32), .NREQ(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ctrl  (req_ctrl),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_zero  (rsp_zero),
    .rsp_id    (rsp_id)
  );

  function automatic logic [31:0] aluRef(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd6:    return a - b;
      4'd7:    return (a < b) ? 32'd1 : 32'd0;
      4'd12:   return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  // Index of the requester that should win now, or -1 if there is no winner.
  function automatic int modelGrant();
    bit slotFree;
    slotFree = !mFull || (rsp_ready[mId] == 1'b1);
    if (!slotFree) return -1;
`ifdef RISCV_ALU_ARB_RR_EN
    for (int k = 1; k <= 2; k++) begin
      if (req_valid[(mLast + k) % 2]) return (mLast + k) % 2;
    end
`else
    for (int i = 0; i < 2; i++) begin
      if (req_valid[i]) return i;
    end
`endif
    return -1;
  endfunction

  function automatic logic [1:0] modelReqReady();
    int g;
    g = modelGrant();
    return (g < 0) ? 2'b00 : 2'(1 << g);
  endfunction

  function automatic logic [1:0] modelRspValid();
    return mFull ? 2'(1 << mId) : 2'b00;
  endfunction

  task automatic modelReset();
    mFull = 0;
    mId   = 0;
    mData = 32'd0;
    mZero = 1;
    mLast = 1;
  endtask

  task automatic setReq(input int i, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_ctrl[i*4 +: 4] = c;
  endtask

  // Advance one clock. The model is updated from the inputs sampled before
  // the edge, and the outputs are sampled 1 ns after the edge.
  task automatic tick();
    int g;
    bit drained;
    g = modelGrant();
    drained = mFull && (rsp_ready[mId] == 1'b1);
    @(posedge clk);
    if (rst) begin
      modelReset();
    end else if (g >= 0) begin
      mData = aluRef(req_ctrl[g*4 +: 4], req_a[g*32 +: 32], req_b[g*32 +: 32]);
      mZero = (mData == 32'd0);
      mId   = g;
      mFull = 1;
      mLast = g;
    end else if (drained) begin
      mFull = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_a = '0;
    req_b = '0;
    req_ctrl = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 2'b00) begin errors++; $display("[TB] FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
    checks++;
    if (rsp_data !== 32'd0) begin errors++; $display("[TB] FAIL reset_rsp_data got=%h exp=0", rsp_data); end
    checks++;
    if (rsp_zero !== 1'b1) begin errors++; $display("[TB] FAIL reset_rsp_zero got=%b exp=1", rsp_zero); end
    checks++;
    if (rsp_id !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
    checks++;
    if (req_ready !== 2'b00) begin errors++; $display("[TB] FAIL reset_req_ready got=%b exp=00", req_ready); end
  endtask

  task automatic test_add();
    setReq(0, 4'b0010, 32'd5, 32'd7);
    req_valid = 2'b01;
    rsp_ready = 2'b01;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("[TB] FAIL add_req_ready got=%b exp=01", req_ready); end
    tick();
    req_valid = 2'b00;
    checks++;
    if (rsp_valid !== 2'b01) begin errors++; $display("[TB] FAIL add_rsp_valid got=%b exp=01", rsp_valid); end
    checks++;
    if (rsp_data !== 32'd12) begin errors++; $display("[TB] FAIL add_rsp_data got=%0d exp=12", rsp_data); end
    checks++;
    if (rsp_zero !== 1'b0) begin errors++; $display("[TB] FAIL add_rsp_zero got=%b exp=0", rsp_zero); end
    checks++;
    if (rsp_id !== 1'b0) begin errors++; $display("[TB] FAIL add_rsp_id got=%0d exp=0", rsp_id); end
    tick();
    checks++;
    if (rsp_valid !== 2'b00) begin errors++; $display("[TB] FAIL add_drain got=%b exp=00", rsp_valid); end
  endtask

  task automatic test_stall();
    setReq(1, 4'b0110, 32'd3, 32'd3);
    setReq(0, 4'b0010, 32'd1, 32'd1);
    req_valid = 2'b10;
    rsp_ready = 2'b00;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin errors++; $display("[TB] FAIL stall_grant got=%b exp=10", req_ready); end
    tick();
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      // The non-owner's ready must have no effect on the held result.
      rsp_ready = (i % 2 == 1) ? 2'b01 : 2'b00;
      #1;
      checks++;
      if (req_ready !== 2'b00) begin errors++; $display("[TB] FAIL stall_req_ready[%0d] got=%b exp=00", i, req_ready); end
      checks++;
      if (rsp_valid !== 2'b10 || rsp_data !== 32'd0 || rsp_zero !== 1'b1 || rsp_id !== 1'b1) begin
        errors++;
        $display("[TB] FAIL stall_hold[%0d] got valid=%b data=%h zero=%b id=%0d exp valid=10 data=0 zero=1 id=1",
                 i, rsp_valid, rsp_data, rsp_zero, rsp_id);
      end
      tick();
    end
    req_valid = 2'b00;
    rsp_ready = 2'b10;
    tick();
    checks++;
    if (rsp_valid !== 2'b00) begin errors++; $display("[TB] FAIL stall_drain got=%b exp=00", rsp_valid); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] expSeq [4];
`ifdef RISCV_ALU_ARB_RR_EN
    expSeq = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    expSeq = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    setReq(0, 4'b0010, 32'd10, 32'd1);
    setReq(1, 4'b0001, 32'hF0, 32'h0F);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (req_ready !== expSeq[i] || req_ready !== modelReqReady()) begin
        errors++;
        $display("[TB] FAIL b2b_grant[%0d] got=%b exp=%b", i, req_ready, expSeq[i]);
      end
      tick();
      checks++;
      if (rsp_data !== mData || rsp_id !== 1'(mId) || rsp_valid !== modelRspValid()) begin
        errors++;
        $display("[TB] FAIL b2b_rsp[%0d] got data=%h id=%0d valid=%b exp data=%h id=%0d valid=%b",
                 i, rsp_data, rsp_id, rsp_valid, mData, mId, modelRspValid());
      end
    end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_slt_nor();
    setReq(0, 4'b0111, 32'hFFFF_FFFF, 32'd1);
    req_valid = 2'b01;
    rsp_ready = 2'b01;
    tick();
    req_valid = 2'b00;
    checks++;
    if (rsp_data !== 32'd0 || rsp_zero !== 1'b1) begin
      errors++;
      $display("[TB] FAIL slt_unsigned got data=%h zero=%b exp data=0 zero=1", rsp_data, rsp_zero);
    end
    setReq(0, 4'b1100, 32'd0, 32'd0);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    checks++;
    if (rsp_data !== 32'hFFFF_FFFF || rsp_zero !== 1'b0 || rsp_valid !== 2'b01) begin
      errors++;
      $display("[TB] FAIL nor got data=%h zero=%b valid=%b exp data=ffffffff zero=0 valid=01", rsp_data, rsp_zero, rsp_valid);
    end
    tick();
  endtask

  task automatic test_illegal();
    setReq(1, 4'b1111, 32'd123, 32'd456);
    req_valid = 2'b10;
    rsp_ready = 2'b10;
    tick();
    req_valid = 2'b00;
    checks++;
    if (rsp_data !== 32'd0 || rsp_zero !== 1'b1 || rsp_id !== 1'b1) begin
      errors++;
      $display("[TB] FAIL illegal_ctrl got data=%h zero=%b id=%0d exp data=0 zero=1 id=1", rsp_data, rsp_zero, rsp_id);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    setReq(1, 4'b0010, 32'd1, 32'd1);
    req_valid = 2'b10;
    rsp_ready = 2'b00;
    tick();
    req_valid = 2'b00;
    checks++;
    if (rsp_id !== 1'b1 || rsp_valid !== 2'b10) begin
      errors++;
      $display("[TB] FAIL rstmid_full got id=%0d valid=%b exp id=1 valid=10", rsp_id, rsp_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (rsp_valid !== 2'b00) begin errors++; $display("[TB] FAIL rstmid_valid got=%b exp=00", rsp_valid); end
    setReq(0, 4'b0010, 32'd2, 32'd2);
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("[TB] FAIL rstmid_winner got=%b exp=01", req_ready); end
    tick();
    req_valid = 2'b00;
    checks++;
    if (rsp_id !== 1'b0 || rsp_data !== 32'd4) begin
      errors++;
      $display("[TB] FAIL rstmid_rsp got id=%0d data=%0d exp id=0 data=4", rsp_id, rsp_data);
    end
    rsp_ready = 2'b01;
    tick();
  endtask

  task automatic test_random();
    logic [3:0] ops [8];
    ops = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd3, 4'd15};
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 2; i++) begin
        setReq(i, ops[$urandom_range(0, 7)], $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom);
      end
      req_valid = 2'($urandom_range(0, 3));
      rsp_ready = 2'($urandom_range(0, 3));
      #1;
      checks++;
      if (req_ready !== modelReqReady()) begin
        errors++;
        $display("[TB] FAIL rand_req_ready[%0d] got=%b exp=%b", n, req_ready, modelReqReady());
      end
      tick();
      checks++;
      if (rsp_valid !== modelRspValid() || rsp_data !== mData || rsp_zero !== mZero || rsp_id !== 1'(mId)) begin
        errors++;
        $display("[TB] FAIL rand_rsp[%0d] got valid=%b data=%h zero=%b id=%0d exp valid=%b data=%h zero=%b id=%0d",
                 n, rsp_valid, rsp_data, rsp_zero, rsp_id, modelRspValid(), mData, mZero, mId);
      end
    end
  endtask

  initial begin
    modelReset();
    #2;
    test_reset();
    test_add();
    test_stall();
    test_back_to_back();
    test_slt_nor();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
